aes_encrypt_core: RTL and testbench



---
 rtl/aes_pkg.sv | 28 ++
 rtl/aes_sbox.sv | 32 +++
 rtl/aes_encrypt_core.sv | 91 +++++++++
 tb/tb_aes_encrypt_core.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers used by the encryption core.
package aes_pkg;

    typedef logic [15:0][7:0] aes_block_t;

    localparam logic [3:0] NR       = 4'd10;
    localparam int         NB_BYTES = 16;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // col[3] holds row 0 of the column and col[0] holds row 3.
    function automatic logic [3:0][7:0] mix_column(input logic [3:0][7:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[3];
        a1 = col[2];
        a2 = col[1];
        a3 = col[0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, looked up from a packed 256-byte constant table.
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] result
);

    // Entry 0 occupies the most significant byte, so the bit offset uses the complemented index.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_base;

    assign bit_base = {~value, 3'b000};
    assign result   = SBOX_TABLE[bit_base +: 8];

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core: one round per clock, valid/ready handshakes on input and output.
module aes_encrypt_core
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0][7:0]  plaintext,
    input  logic [15:0][7:0]  key,
    input  logic [159:0][7:0] round_keys,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0][7:0]  ciphertext,
    output logic              busy
);

    aes_fsm_t   fsm, fsm_next;
    logic [3:0] rnd;
    logic [3:0] rk_index;
    logic       load;
    aes_block_t state;
    aes_block_t sub_bytes, shifted, mixed, round_key, round_out;

    for (genvar i = 0; i < NB_BYTES; i++) begin : g_sbox
        aes_sbox u_sbox (
            .value  (state[i]),
            .result (sub_bytes[i])
        );
    end

    // Byte i is row (15-i)%4, column (15-i)/4; ShiftRows rotates row r left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shifted[15 - (4 * c + r)] = sub_bytes[15 - (4 * ((c + r) % 4) + r)];
        end
        assign mixed[(3 - c) * 4 +: 4] = mix_column(shifted[(3 - c) * 4 +: 4]);
    end

    assign rk_index  = (rnd >= 4'd1 && rnd <= NR) ? rnd - 4'd1 : 4'd0;
    assign round_key = round_keys[{rk_index, 4'b0000} +: 16];
    assign round_out = ((rnd == NR) ? shifted : mixed) ^ round_key;
    assign load      = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm   <= IDLE;
            rnd   <= 4'd0;
            state <= '0;
        end else begin
            fsm <= fsm_next;
            if (load) begin
                state <= plaintext ^ key;
                rnd   <= 4'd1;
            end else if (fsm == ROUND) begin
                state <= round_out;
                rnd   <= rnd + 4'd1;
            end
        end
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (in_valid) fsm_next = ROUND;
            ROUND:   if (rnd == NR) fsm_next = DONE;
            DONE:    if (out_ready) fsm_next = in_valid ? ROUND : IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    // Ciphertext is gated to DONE so intermediate round states never leave the core.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        ciphertext = '0;
        case (fsm)
            IDLE: in_ready = 1'b1;
            ROUND: busy = 1'b1;
            DONE: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                in_ready   = out_ready;
                ciphertext = state;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Self-checking bench for aes_encrypt_core: known answers, handshake corner cases and random blocks vs a reference model.
module tb_aes_encrypt_core;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [15:0][7:0]  plaintext;
    logic [15:0][7:0]  key;
    logic [159:0][7:0] round_keys;
    logic              out_valid;
    logic              out_ready;
    logic [15:0][7:0]  ciphertext;
    logic              busy;

    int         tests_run;
    int         tests_failed;
    int         cyc;
    logic [7:0] sb [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_encrypt_core dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .round_keys (round_keys),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [1279:0] expand_key(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1279:0] rks;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcon, 24'h000000};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 1; r <= 10; r++)
            rks[128 * (r - 1) +: 128] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        return rks;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [1279:0] rks;
        logic [127:0]  rk;
        logic [127:0]  res;
        logic [7:0]    s [4][4];
        logic [7:0]    t [4][4];
        rks = expand_key(k);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127 - 8 * (4 * c + r) -: 8] ^ k[127 - 8 * (4 * c + r) -: 8];
        for (int n = 1; n <= 10; n++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = sb[s[r][(c + r) % 4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (n < 10)
                        s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r + 1) % 4][c])
                                ^ t[(r + 2) % 4][c] ^ t[(r + 3) % 4][c];
                    else
                        s[r][c] = t[r][c];
            rk = rks[128 * (n - 1) +: 128];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = s[r][c] ^ rk[127 - 8 * (4 * c + r) -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8 * (4 * c + r) -: 8] = s[r][c];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] expected);
        tests_run++;
        if (got !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k, output int acc_cyc);
        logic accepted;
        plaintext  = pt;
        key        = k;
        round_keys = expand_key(k);
        in_valid   = 1'b1;
        accepted   = 1'b0;
        #1;
        for (int i = 0; i < 60 && !accepted; i++) begin
            accepted = in_ready;
            tick();
        end
        acc_cyc  = cyc;
        in_valid = 1'b0;
        checkOutput("accept", 128'(accepted), 128'd1);
    endtask

    task automatic waitOutput(output logic [127:0] ct, output int out_cyc);
        logic seen;
        seen = out_valid;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            seen = out_valid;
        end
        checkOutput("out_valid seen", 128'(seen), 128'd1);
        ct      = ciphertext;
        out_cyc = cyc;
    endtask

    task automatic runBlock(input string tag, input logic [127:0] pt, input logic [127:0] k,
                            input logic [127:0] expected);
        int           a;
        int           o;
        logic [127:0] ct;
        out_ready = 1'b1;
        applyStimulus(pt, k, a);
        waitOutput(ct, o);
        checkOutput(tag, ct, expected);
        checkOutput({tag, " latency"}, 128'(o - a), 128'd10);
        tick();
        checkOutput({tag, " out_valid after handshake"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        int           a1, o1, o2;
        int           hold;
        logic         acc;
        logic [127:0] ct, ct2, pa, ka, pb, kb, expected;

        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        plaintext    = '0;
        key          = '0;
        round_keys   = '0;
        buildSbox();

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset busy", 128'(busy), 128'd0);
        checkOutput("reset ciphertext", 128'(ciphertext), 128'd0);
        checkOutput("reset in_ready", 128'(in_ready), 128'd1);

        // FIPS-197 C.1 with busy/in_ready observed during the rounds.
        applyStimulus(C1_PT, C1_KEY, a1);
        checkOutput("c1 busy in round", 128'(busy), 128'd1);
        checkOutput("c1 in_ready in round", 128'(in_ready), 128'd0);
        waitOutput(ct, o1);
        checkOutput("c1 ciphertext", ct, C1_CT);
        checkOutput("c1 latency", 128'(o1 - a1), 128'd10);
        tick();
        checkOutput("c1 back to idle", 128'(in_ready), 128'd1);

        runBlock("zero ciphertext", 128'd0, 128'd0, ZERO_CT);

        // Backpressure: output must hold while the consumer stalls.
        pa = rand128();
        ka = rand128();
        expected  = model_encrypt(pa, ka);
        out_ready = 1'b0;
        applyStimulus(pa, ka, a1);
        waitOutput(ct, o1);
        checkOutput("bp ciphertext", ct, expected);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp out_valid held", 128'(out_valid), 128'd1);
            checkOutput("bp ciphertext held", 128'(ciphertext), expected);
            checkOutput("bp in_ready low", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp in_ready with out_ready", 128'(in_ready), 128'd1);
        tick();
        checkOutput("bp released", 128'(out_valid), 128'd0);

        // Back-to-back: second block is loaded in the first block's DONE cycle.
        pa = rand128();
        ka = rand128();
        pb = rand128();
        kb = rand128();
        plaintext  = pa;
        key        = ka;
        round_keys = expand_key(ka);
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        acc        = 1'b0;
        #1;
        for (int i = 0; i < 60 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        checkOutput("b2b accept first", 128'(acc), 128'd1);
        waitOutput(ct, o1);
        plaintext  = pb;
        key        = kb;
        round_keys = expand_key(kb);
        #1;
        checkOutput("b2b in_ready in done", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("b2b reload busy", 128'(busy), 128'd1);
        checkOutput("b2b out_valid drop", 128'(out_valid), 128'd0);
        waitOutput(ct2, o2);
        checkOutput("b2b first ciphertext", ct, model_encrypt(pa, ka));
        checkOutput("b2b second ciphertext", ct2, model_encrypt(pb, kb));
        checkOutput("b2b spacing", 128'(o2 - o1), 128'd11);
        tick();

        // Reset in the middle of the rounds abandons the block.
        applyStimulus(C1_PT, C1_KEY, a1);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        checkOutput("midreset out_valid", 128'(out_valid), 128'd0);
        checkOutput("midreset busy", 128'(busy), 128'd0);
        checkOutput("midreset in_ready", 128'(in_ready), 128'd1);
        checkOutput("midreset ciphertext", 128'(ciphertext), 128'd0);
        rst = 1'b0;
        runBlock("post reset c1", C1_PT, C1_KEY, C1_CT);

        // Junk requests while busy must be ignored.
        applyStimulus(C1_PT, C1_KEY, a1);
        for (int i = 0; i < 8; i++) begin
            in_valid  = (i % 2 == 0);
            plaintext = rand128();
            tick();
        end
        in_valid = 1'b0;
        waitOutput(ct, o1);
        checkOutput("junk c1 ciphertext", ct, C1_CT);
        checkOutput("junk c1 latency", 128'(o1 - a1), 128'd10);
        tick();

        // Random blocks with random stall lengths.
        for (int n = 0; n < 10; n++) begin
            pa = rand128();
            ka = rand128();
            expected  = model_encrypt(pa, ka);
            out_ready = 1'b0;
            hold      = int'($urandom_range(3, 0));
            applyStimulus(pa, ka, a1);
            waitOutput(ct, o1);
            checkOutput("rand ciphertext", ct, expected);
            checkOutput("rand latency", 128'(o1 - a1), 128'd10);
            for (int h = 0; h < hold; h++) begin
                tick();
                checkOutput("rand held", 128'(ciphertext), expected);
            end
            out_ready = 1'b1;
            tick();
            checkOutput("rand released", 128'(out_valid), 128'd0);
            repeat ($urandom_range(2, 0)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
